// File: rtl/syn_i2c_pkg.sv
// syn_i2c_pkg: state enum and bus constants shared by the I2C master and slave
package syn_i2c_pkg;
  localparam int P_I2C_CYCLE_W = 8;
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  typedef enum logic [2:0] {IDLE_S, ADDR_S, ADDR_ACK_S, DATA_S, DATA_ACK_S, WAIT_STOP_S} i2c_state_e;
endpackage

// File: rtl/syn_i2c_slave_if.sv
// syn_i2c_slave_if: pin and write-port bundle of the I2C slave
interface syn_i2c_slave_if #(parameter int DW = 16);
  logic scl_i;
  logic sda_i;
  logic sda_oe;
  logic wr_valid;
  logic [DW-1:0] wr_data;
  logic busy;
  logic nack_flag;
  modport slave(input scl_i, sda_i, output sda_oe, wr_valid, wr_data, busy, nack_flag);
  modport master(output scl_i, sda_i, input sda_oe, wr_valid, wr_data, busy, nack_flag);
endinterface

// File: rtl/syn_i2c_line_sync.sv
// syn_i2c_line_sync: 2-FF sync, optional glitch filter (SYN_I2C_SLAVE_GLITCH_FILT_EN), edge strobes
module syn_i2c_line_sync
`ifdef SYN_I2C_SLAVE_GLITCH_FILT_EN
  #(parameter int P_FILT_W = 3)
`endif
  (
  input  logic clk_ir,
  input  logic rst_sync,
  input  logic line_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic lvl;
  assign sync_d = {sync_q[0], line_i};
  assign prev_d = lvl;
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
`ifdef SYN_I2C_SLAVE_GLITCH_FILT_EN
  localparam int CW = $clog2(P_FILT_W + 1);
  logic filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // the filtered level flips only on the P_FILT_W-th consecutive differing sample
  always_comb begin
    filt_d = filt_q;
    cnt_d = '0;
    if (sync_q[1] != filt_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(P_FILT_W - 1)) begin
        filt_d = sync_q[1];
        cnt_d = '0;
      end
    end
  end
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      filt_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q <= cnt_d;
    end
  end
  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif
  assign lvl_o = lvl;
  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;
endmodule

// File: rtl/syn_i2c_slave.sv
// syn_i2c_slave: write-only I2C responder; ACKs matching writes and emits one pulse per full word
module syn_i2c_slave
  import syn_i2c_pkg::*;
#(
  parameter logic [6:0] P_DEV_ADDR = 7'h1A,
  parameter int P_NUM_DATA_BYTES = 2
`ifdef SYN_I2C_SLAVE_GLITCH_FILT_EN
  , parameter int P_FILT_W = 3
`endif
) (
  input logic clk_ir,
  input logic rst_sync,
  syn_i2c_slave_if.slave bus
);
  localparam int DW = 8 * P_NUM_DATA_BYTES;
  localparam int BW = (P_NUM_DATA_BYTES > 1) ? $clog2(P_NUM_DATA_BYTES) : 1;
  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
`ifdef SYN_I2C_SLAVE_GLITCH_FILT_EN
  syn_i2c_line_sync #(.P_FILT_W(P_FILT_W)) u_scl (
`else
  syn_i2c_line_sync u_scl (
`endif
    .clk_ir(clk_ir), .rst_sync(rst_sync), .line_i(bus.scl_i),
    .lvl_o(scl), .rise_o(scl_rise), .fall_o(scl_fall));
`ifdef SYN_I2C_SLAVE_GLITCH_FILT_EN
  syn_i2c_line_sync #(.P_FILT_W(P_FILT_W)) u_sda (
`else
  syn_i2c_line_sync u_sda (
`endif
    .clk_ir(clk_ir), .rst_sync(rst_sync), .line_i(bus.sda_i),
    .lvl_o(sda), .rise_o(sda_rise), .fall_o(sda_fall));
  i2c_state_e state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [P_I2C_CYCLE_W-1:0] shift_q, shift_d;
  logic got_q, got_d;
  logic [DW-1:0] stage_q, stage_d, data_q, data_d;
  logic oe_q, oe_d, valid_q, valid_d, nack_q, nack_d;
  logic start, stop, shifting;
  assign start = sda_fall & scl;
  assign stop = sda_rise & scl;
  assign shifting = state_q == ADDR_S || state_q == DATA_S || state_q == WAIT_STOP_S;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    byte_d = byte_q;
    shift_d = shift_q;
    got_d = got_q;
    stage_d = stage_q;
    oe_d = oe_q;
    valid_d = 1'b0;
    data_d = data_q;
    nack_d = nack_q;
    if (stop) begin
      state_d = IDLE_S;
      oe_d = 1'b0;
    end else if (start) begin
      state_d = ADDR_S;
      bit_d = '0;
      byte_d = '0;
      got_d = 1'b0;
      oe_d = 1'b0;
      nack_d = 1'b0;
    end else begin
      if (scl_rise && shifting) begin
        shift_d = {shift_q[P_I2C_CYCLE_W-2:0], sda};
        bit_d = bit_q + 3'd1;
        got_d = bit_q == 3'd7;
      end
      // every state transition happens on the SCL fall that ends a bit
      if (scl_fall) begin
        case (state_q)
          ADDR_S: if (got_q) begin
            got_d = 1'b0;
            if (shift_q == {P_DEV_ADDR, 1'b0}) begin
              state_d = ADDR_ACK_S;
              oe_d = 1'b1;
            end else begin
              state_d = WAIT_STOP_S;
              nack_d = 1'b1;
            end
          end
          ADDR_ACK_S: begin
            state_d = DATA_S;
            oe_d = 1'b0;
            byte_d = '0;
            bit_d = '0;
          end
          DATA_S: if (got_q) begin
            got_d = 1'b0;
            for (int i = 0; i < P_NUM_DATA_BYTES; i++)
              if (byte_q == BW'(i)) stage_d[8*(P_NUM_DATA_BYTES-1-i) +: 8] = shift_q;
            state_d = DATA_ACK_S;
            oe_d = 1'b1;
          end
          DATA_ACK_S: begin
            oe_d = 1'b0;
            bit_d = '0;
            if (byte_q == BW'(P_NUM_DATA_BYTES - 1)) begin
              valid_d = 1'b1;
              data_d = stage_q;
              state_d = WAIT_STOP_S;
            end else begin
              byte_d = byte_q + 1'b1;
              state_d = DATA_S;
            end
          end
          WAIT_STOP_S: if (got_q) begin
            got_d = 1'b0;
            nack_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk_ir) begin
    if (rst_sync) begin
      state_q <= IDLE_S;
      bit_q <= '0;
      byte_q <= '0;
      shift_q <= '0;
      got_q <= 1'b0;
      stage_q <= '0;
      oe_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      nack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      shift_q <= shift_d;
      got_q <= got_d;
      stage_q <= stage_d;
      oe_q <= oe_d;
      valid_q <= valid_d;
      data_q <= data_d;
      nack_q <= nack_d;
    end
  end
  assign bus.sda_oe = oe_q;
  assign bus.wr_valid = valid_q;
  assign bus.wr_data = data_q;
  assign bus.busy = state_q != IDLE_S;
  assign bus.nack_flag = nack_q;
endmodule

// File: tb/tb_syn_i2c_slave.sv
// tb_syn_i2c_slave: bit-banged I2C master with a transaction-level model of expected ACKs and words
module tb_syn_i2c_slave;
  localparam int Q = 25;
  localparam int N = 2;
  logic clk_ir = 1'b0;
  logic rst_sync = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  int checks = 0;
  int errs = 0;
  int pulses = 0;
  bit oe_seen = 1'b0;
  bit busy_seen = 1'b0;
  logic [15:0] exp_word = 16'h0;
  syn_i2c_slave_if #(.DW(16)) bus();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;
  syn_i2c_slave #(.P_DEV_ADDR(7'h1A), .P_NUM_DATA_BYTES(N)) dut (
    .clk_ir(clk_ir), .rst_sync(rst_sync), .bus(bus));
  always #10 clk_ir = ~clk_ir;
  always @(negedge clk_ir) begin
    if (bus.wr_valid === 1'b1) pulses++;
    if (bus.sda_oe === 1'b1) oe_seen = 1'b1;
    if (bus.busy === 1'b1) busy_seen = 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wq();
    repeat (Q) @(negedge clk_ir);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq(); wq();
  endtask
  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wq();
      scl_m = 1'b1; wq(); wq();
      scl_m = 1'b0; wq();
    end
  endtask
  task automatic ack_clk(output logic ack);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    ack = bus.sda_i; wq();
    scl_m = 1'b0; wq();
  endtask
  task automatic txn(input logic [7:0] a, input int n, input logic [23:0] dd, input bit do_stop);
    logic ack;
    bit aok;
    int exp_p;
    aok = a == 8'h34;
    exp_p = (aok && n >= N) ? 1 : 0;
    pulses = 0;
    oe_seen = 1'b0;
    i2c_start();
    chk("busy_after_start", bus.busy, 1);
    chk("nack_cleared", bus.nack_flag, 0);
    send_bits(a);
    ack_clk(ack);
    chk("addr_ack", ack, aok ? 0 : 1);
    for (int i = 0; i < n; i++) begin
      send_bits(dd[23-8*i -: 8]);
      ack_clk(ack);
      chk("data_ack", ack, (aok && i < N) ? 0 : 1);
    end
    if (exp_p == 1) exp_word = dd[23:8];
    if (do_stop) begin
      i2c_stop();
      chk("busy_after_stop", bus.busy, 0);
    end else chk("busy_held", bus.busy, 1);
    chk("wr_pulses", pulses, exp_p);
    chk("wr_data", bus.wr_data, exp_word);
    chk("nack_flag", bus.nack_flag, (!aok || n > N) ? 1 : 0);
    chk("oe_seen", oe_seen, aok ? 1 : 0);
  endtask
  initial begin
    logic [7:0] ra;
    repeat (5) @(negedge clk_ir);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_wr_valid", bus.wr_valid, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_nack", bus.nack_flag, 0);
    rst_sync = 1'b0;
    wq();
    txn(8'h34, 2, 24'h1E0000, 1'b1);
    txn(8'h36, 0, 24'h0, 1'b1);
    txn(8'h35, 1, 24'h550000, 1'b1);
    txn(8'h34, 1, 24'hAA0000, 1'b1);
    txn(8'h34, 1, 24'h120000, 1'b0);
    txn(8'h34, 2, 24'h0C9F00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
      txn(ra, $urandom_range(0, 3), 24'($urandom), 1'b1);
    end
    i2c_start();
    send_bits(8'h34);
    wq();
    chk("oe_before_rst", bus.sda_oe, 1);
    rst_sync = 1'b1;
    @(negedge clk_ir);
    chk("oe_after_rst", bus.sda_oe, 0);
    chk("busy_after_rst", bus.busy, 0);
    rst_sync = 1'b0;
    exp_word = 16'h0;
    chk("wr_data_after_rst", bus.wr_data, exp_word);
    scl_m = 1'b1; wq();
    scl_m = 1'b0; wq();
    i2c_stop();
    busy_seen = 1'b0;
    sda_m = 1'b0;
    repeat (2) @(negedge clk_ir);
    sda_m = 1'b1;
    wq();
`ifdef SYN_I2C_SLAVE_GLITCH_FILT_EN
    chk("glitch_start", busy_seen, 0);
`else
    chk("glitch_start", busy_seen, 1);
`endif
    scl_m = 1'b0; wq();
    i2c_stop();
    chk("idle_end", bus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
